// File: rtl/rtu_req_arbiter.sv
// rtu_req_arbiter: shares one RTU lookup engine between g_num_ports request channels.
// Round-robin grant in IDLE, one lookup in flight, response routed back to the owner,
// watchdog completion with rsp_err_o when the engine never answers.
module rtu_req_arbiter #(
   parameter int unsigned g_num_ports = 18,
   parameter int unsigned g_key_width = 112,
   parameter int unsigned g_rsp_width = 40,
   parameter int unsigned g_timeout   = 1024
) (
   input  logic                               clk_sys_i,
   input  logic                               rst_i,
   input  logic [g_num_ports-1:0]             port_en_i,
   input  logic [g_num_ports-1:0]             req_valid_i,
   input  logic [g_num_ports*g_key_width-1:0] req_key_i,
   output logic [g_num_ports-1:0]             req_ack_o,
   output logic                               eng_req_o,
   input  logic                               eng_rdy_i,
   output logic [g_key_width-1:0]             eng_key_o,
   output logic [4:0]                         eng_port_o,
   input  logic                               eng_rsp_valid_i,
   input  logic [g_rsp_width-1:0]             eng_rsp_i,
   output logic [g_num_ports-1:0]             rsp_valid_o,
   output logic [g_rsp_width-1:0]             rsp_data_o,
   output logic                               rsp_err_o,
   output logic                               busy_o,
   output logic [15:0]                        stale_cnt_o
);

   localparam int unsigned CntWidth = (g_timeout > 2) ? $clog2(g_timeout) : 1;
   localparam logic [CntWidth-1:0] CntMax = CntWidth'(g_timeout - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDeliver} state_e;

   state_e                   state_q;
   logic [4:0]               rr_ptr_q;
   logic [CntWidth-1:0]      cnt_q;
   logic [g_num_ports-1:0]   req_ack_q;
   logic                     eng_req_q;
   logic [g_key_width-1:0]   eng_key_q;
   logic [4:0]               eng_port_q;
   logic [g_num_ports-1:0]   rsp_valid_q;
   logic [g_rsp_width-1:0]   rsp_data_q;
   logic                     rsp_err_q;
   logic [15:0]              stale_q;

   logic [g_num_ports-1:0]   eligible;
   logic [5:0]               cand;
   logic                     grant_vld_d;
   logic [4:0]               grant_idx_d;
   logic [g_key_width-1:0]   grant_key_d;
   logic [g_num_ports-1:0]   grant_oh;
   logic [g_num_ports-1:0]   owner_oh;

   assign eligible = req_valid_i & port_en_i;
   assign grant_oh = g_num_ports'(1) << grant_idx_d;
   assign owner_oh = g_num_ports'(1) << eng_port_q;

   // Round-robin search starting just after the last served port, wrapping at g_num_ports.
   always_comb begin
      grant_vld_d = 1'b0;
      grant_idx_d = '0;
      grant_key_d = '0;
      cand        = '0;
      for (int unsigned i = 1; i <= g_num_ports; i++) begin
         cand = 6'(rr_ptr_q) + 6'(i);
         if (cand >= 6'(g_num_ports)) cand = cand - 6'(g_num_ports);
         if (!grant_vld_d && eligible[cand[4:0]]) begin
            grant_vld_d = 1'b1;
            grant_idx_d = cand[4:0];
         end
      end
      for (int unsigned p = 0; p < g_num_ports; p++) begin
         if (grant_idx_d == 5'(p)) grant_key_d = req_key_i[p*g_key_width +: g_key_width];
      end
   end

   // Arbitration FSM with all outputs registered; reset abandons any in-flight lookup.
   always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         rr_ptr_q    <= 5'(g_num_ports - 1);
         cnt_q       <= '0;
         req_ack_q   <= '0;
         eng_req_q   <= 1'b0;
         eng_key_q   <= '0;
         eng_port_q  <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         stale_q     <= '0;
      end else begin
         req_ack_q   <= '0;
         rsp_valid_q <= '0;
         // Responses outside WAIT belong to no live lookup.
         if (eng_rsp_valid_i && (state_q != StWait) && (stale_q != 16'hFFFF)) begin
            stale_q <= stale_q + 16'd1;
         end
         case (state_q)
            StIdle: begin
               if (grant_vld_d) begin
                  eng_port_q <= grant_idx_d;
                  eng_key_q  <= grant_key_d;
                  req_ack_q  <= grant_oh;
                  eng_req_q  <= 1'b1;
                  state_q    <= StIssue;
               end
            end
            StIssue: begin
               if (eng_rdy_i) begin
                  eng_req_q <= 1'b0;
                  cnt_q     <= '0;
                  state_q   <= StWait;
               end
            end
            StWait: begin
               cnt_q <= cnt_q + CntWidth'(1);
               // A response in the timeout cycle still counts as a normal completion.
               if (eng_rsp_valid_i) begin
                  rsp_data_q  <= eng_rsp_i;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= owner_oh;
                  state_q     <= StDeliver;
               end else if (cnt_q == CntMax) begin
                  rsp_data_q  <= '0;
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= owner_oh;
                  state_q     <= StDeliver;
               end
            end
            StDeliver: begin
               rr_ptr_q <= eng_port_q;
               state_q  <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign req_ack_o   = req_ack_q;
   assign eng_req_o   = eng_req_q;
   assign eng_key_o   = eng_key_q;
   assign eng_port_o  = eng_port_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_err_o   = rsp_err_q;
   assign busy_o      = (state_q != StIdle);
   assign stale_cnt_o = stale_q;

endmodule

// File: doc/rtu_req_arbiter.md
Name: rtu_req_arbiter

Overview:
- Shares a single RTU lookup engine between g_num_ports endpoint request channels.
- Work-conserving round-robin arbitration, one lookup in flight at a time.
- Routes each engine response back to the requesting port.
- Watchdog timeout so a stalled engine cannot hang a port.
- Sits between the per-port RTU request outputs of the endpoints and the RTU match engine inside the switch core.

Parameters:
- g_num_ports, 18, number of requesting ports (1..32)
- g_key_width, 112, lookup key width per port (smac, dmac, vid, prio, flags)
- g_rsp_width, 40, engine response width (port mask, drop, prio)
- g_timeout, 1024, cycles to wait for an engine response before an error completion (>=2)

Ports:
- clk_sys_i  in  1  system clock
- rst_i  in  1  synchronous reset, active high
- port_en_i  in  g_num_ports  per-port arbitration enable
- req_valid_i  in  g_num_ports  per-port lookup request; held until acked
- req_key_i  in  g_num_ports*g_key_width  flattened keys; port p at bits [p*g_key_width +: g_key_width]
- req_ack_o  out  g_num_ports  one-cycle acceptance pulse to the granted port
- eng_req_o  out  1  request valid to the engine
- eng_rdy_i  in  1  engine accepts the request
- eng_key_o  out  g_key_width  latched key of the granted port
- eng_port_o  out  5  index of the granted port
- eng_rsp_valid_i  in  1  engine response strobe
- eng_rsp_i  in  g_rsp_width  engine response data
- rsp_valid_o  out  g_num_ports  one-cycle response pulse to the owning port
- rsp_data_o  out  g_rsp_width  shared response bus, valid with rsp_valid_o
- rsp_err_o  out  1  completion was a timeout, valid with rsp_valid_o
- busy_o  out  1  high in every state except IDLE
- stale_cnt_o  out  16  saturating count of ignored engine responses

Behaviour:
Reset (rst_i sampled high, at any time including mid-transaction):
- All outputs go to 0; state IDLE.
- rr_ptr = g_num_ports-1, so port 0 has first priority.
- Timeout counter = 0, stale_cnt_o = 0.
- An in-flight lookup is abandoned; a later engine response to it counts as stale.

State machine (IDLE -> ISSUE -> WAIT -> DELIVER -> IDLE):
- **IDLE:**
  - eligible = req_valid_i & port_en_i.
  - If eligible is non-zero, grant the first set bit searching rr_ptr+1, rr_ptr+2, ... wrapping modulo g_num_ports.
  - Register the port index into eng_port_o and its key into eng_key_o.
  - Pulse req_ack_o[p] for exactly one cycle, in the first cycle of ISSUE.
  - Go to ISSUE.
- **ISSUE:**
  - eng_req_o = 1; key and port are held stable.
  - In a cycle with eng_rdy_i = 1, the request is transferred; eng_req_o drops next cycle, the counter clears, and the state goes to WAIT.
- **WAIT:**
  - The counter increments every cycle.
  - If eng_rsp_valid_i = 1: latch eng_rsp_i into rsp_data_o, rsp_err_o = 0, go to DELIVER.
  - Else, if the counter reaches g_timeout-1: rsp_data_o = 0, rsp_err_o = 1, go to DELIVER.
  - A response arriving in the same cycle as the timeout wins; it is a normal completion.
- **DELIVER:**
  - rsp_valid_o[eng_port_o] = 1 for exactly one cycle; rsp_data_o and rsp_err_o are valid in that cycle.
  - rr_ptr = eng_port_o.
  - Return to IDLE.
  - rsp_data_o and rsp_err_o hold their value until the next DELIVER.

Timing:
- Minimum latency is 4 cycles, from req_valid_i sampled in IDLE to rsp_valid_o, when eng_rdy_i is high in the first ISSUE cycle and the response comes the cycle after.
- At most one lookup is outstanding. No request is issued in the DELIVER cycle; the next arbitration happens in IDLE.

Boundary rules:
- eng_rsp_valid_i outside WAIT is ignored and increments stale_cnt_o, saturating at 0xFFFF.
- Deasserting port_en_i or req_valid_i after the grant does not abort the transaction; it completes and is delivered normally.
- A port whose req_valid_i stays high after its ack is a new request. It competes again, with lowest priority immediately after its service.
- A single eligible port is regranted back-to-back, every 4+ cycles.
- eng_port_o is zero-extended, so g_num_ports <= 32.

Test Plan:
- **Single request.** Port 3 requests with key 0x...ABCD; eng_rdy_i=1; response 0x00_0002_0000 after 1 cycle. Expect req_ack_o=0x8 one cycle, eng_port_o=3, eng_key_o=0x...ABCD, rsp_valid_o=0x8 with rsp_data_o=0x00_0002_0000, rsp_err_o=0. Expect 4 cycles from request to response.
- **Round robin.** Ports 0, 5 and 17 hold requests continuously with an immediate-response engine. Expect grant order 0, 5, 17, 0, 5, 17 with no port granted twice in a row while others wait.
- **Enable mask.** port_en_i=0x3FFFE with ports 0 and 1 requesting. Expect only port 1 served; port 0 is never acked until port_en_i[0]=1.
- **Timeout.** g_timeout=16; the engine never responds. Expect rsp_valid_o for the granted port 16 cycles after the ISSUE handshake, rsp_err_o=1, rsp_data_o=0. A response injected 5 cycles later increments stale_cnt_o to 1.
- **Engine backpressure.** eng_rdy_i low for 10 cycles. Expect eng_req_o held high with eng_key_o stable, a single transfer, and no extra ack.
- **Reset mid-WAIT.** Assert rst_i for 1 cycle during WAIT. Expect all outputs 0 and busy_o=0 next cycle, and the next grant goes to the lowest-index requesting port. A late engine response increments stale_cnt_o.
